// File: rtl/mem_arb_pkg.sv
// Shared encodings and request payload for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              req_id;
        logic              we;
        logic [1:0]        size;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } arb_req_t;

    // Number of bytes touched by an access of the given size (illegal treated as word).
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave is the arbiter view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [1:0]        mem_size;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_write_data, mem_write, mem_read, mem_size,
        input  mem_read_data
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_write_data, mem_write, mem_read, mem_size,
        output mem_read_data
    );

endinterface

// File: rtl/mem_arb_chk.sv
// Combinational alignment and range check for a single memory access.
module mem_arb_chk
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 8192
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    output logic              err
);

    logic [ADDR_W:0] last_byte;

    // Flag illegal size, misalignment, or any touched byte past the end of memory.
    always_comb begin
        last_byte = {1'b0, addr} + (ADDR_W + 1)'(size_bytes(size)) - (ADDR_W + 1)'(1);
        err       = 1'b0;
        case (size)
            SZ_HALF: err = addr[0];
            SZ_WORD: err = |addr[1:0];
            SZ_ILL:  err = 1'b1;
            default: err = 1'b0;
        endcase
        if (last_byte >= (ADDR_W + 1)'(MEM_BYTES)) begin
            err = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer sharing one memory port between fetch and load/store.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 8192,
    parameter int unsigned MAX_D_BURST = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_D_BURST + 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    arb_req_t          req_q, req_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              if_err_q, if_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              d_err_q, d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              if_gnt_c;
    logic              d_gnt_c;
    logic              fetch_turn_c;
    logic              req_err_c;
    logic [ADDR_W-1:0] mem_address_c;
    logic [DATA_W-1:0] mem_write_data_c;
    logic              mem_write_c;
    logic              mem_read_c;
    logic [1:0]        mem_size_c;

    mem_arb_chk #(
        .MEM_BYTES (MEM_BYTES)
    ) u_chk (
        .addr (req_q.addr),
        .size (req_q.size),
        .err  (req_err_c)
    );

    // Arbitration in IDLE, memory drive and response capture in BUSY, burst counting.
    always_comb begin
        state_d          = state_q;
        burst_cnt_d      = burst_cnt_q;
        req_d            = req_q;
        if_rvalid_d      = 1'b0;
        if_err_d         = 1'b0;
        if_rdata_d       = if_rdata_q;
        d_rvalid_d       = 1'b0;
        d_err_d          = 1'b0;
        d_rdata_d        = d_rdata_q;
        if_gnt_c         = 1'b0;
        d_gnt_c          = 1'b0;
        mem_address_c    = '0;
        mem_write_data_c = '0;
        mem_write_c      = 1'b0;
        mem_read_c       = 1'b0;
        mem_size_c       = SZ_WORD;
        fetch_turn_c     = (burst_cnt_q == CNT_W'(MAX_D_BURST));

        case (state_q)
            IDLE: begin
                if (bus.if_req && (!bus.d_req || fetch_turn_c)) begin
                    if_gnt_c = 1'b1;
                    req_d    = '{req_id: REQ_IF, we: 1'b0, size: SZ_WORD,
                                 addr: bus.if_addr, wdata: '0};
                    state_d  = BUSY;
                end else if (bus.d_req) begin
                    d_gnt_c  = 1'b1;
                    req_d    = '{req_id: REQ_D, we: bus.d_we, size: bus.d_size,
                                 addr: bus.d_addr, wdata: bus.d_wdata};
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                mem_address_c    = req_q.addr;
                mem_size_c       = req_q.size;
                mem_write_data_c = req_q.wdata;
                mem_read_c       = !req_q.we && !req_err_c;
                mem_write_c      = req_q.we && !req_err_c && !rst;
                if (req_q.req_id == REQ_IF) begin
                    if_rvalid_d = 1'b1;
                    if_err_d    = req_err_c;
                    if_rdata_d  = mem_read_c ? bus.mem_read_data : '0;
                end else begin
                    d_rvalid_d  = 1'b1;
                    d_err_d     = req_err_c;
                    d_rdata_d   = mem_read_c ? bus.mem_read_data : '0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Counts data grants made while a fetch is waiting.
        if (!bus.if_req || if_gnt_c) begin
            burst_cnt_d = '0;
        end else if (d_gnt_c) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
    end

    // State, request and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            req_q       <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_err_q     <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            req_q       <= req_d;
            if_rvalid_q <= if_rvalid_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_err_q     <= d_err_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_gnt         = if_gnt_c;
    assign bus.d_gnt          = d_gnt_c;
    assign bus.if_rvalid      = if_rvalid_q;
    assign bus.if_err         = if_err_q;
    assign bus.if_rdata       = if_rdata_q;
    assign bus.d_rvalid       = d_rvalid_q;
    assign bus.d_err          = d_err_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.mem_address    = mem_address_c;
    assign bus.mem_write_data = mem_write_data_c;
    assign bus.mem_write      = mem_write_c;
    assign bus.mem_read       = mem_read_c;
    assign bus.mem_size       = mem_size_c;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer in front of the unified byte-addressable `Memory` (combinational read, posedge write). It shares the single memory port between the instruction-fetch unit (word reads only) and the load/store unit (byte/half/word reads and writes). It registers each access, checks alignment and range, and returns one-cycle response pulses. It sits between the CPU core and `Memory`; the core never drives `Memory` directly.

## Interface
- `MEM_BYTES`, 8192: memory size in bytes. Addresses `>= MEM_BYTES` are errors.
- `MAX_D_BURST`, 4: consecutive data grants allowed while a fetch waits.
- `clk` in 1: single clock, all state on posedge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1 / `if_addr` in 32: fetch request and its byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1 / `if_rdata` out 32 / `if_err` out 1: fetch response.
- `d_req` in 1 / `d_we` in 1 / `d_size` in 2 / `d_addr` in 32 / `d_wdata` in 32: data request. `d_size` is 00 byte, 01 half, 10 word, 11 illegal.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1 / `d_rdata` out 32 / `d_err` out 1: data response. Writes also get a response.
- `mem_address` out 32 / `mem_write_data` out 32 / `mem_write` out 1 / `mem_read` out 1 / `mem_size` out 2: drive `Memory`.
- `mem_read_data` in 32: `Memory` read output.

## Operation
- FSM states: IDLE, BUSY. Reset puts the FSM in IDLE.
- Reset values of registered outputs: `*_rvalid`, `*_err`, `*_rdata` = 0.
- Default memory drive outside BUSY: `mem_*` = 0, except `mem_size` = 10.
- Grant and acceptance:
  - `*_gnt` is combinational and asserted only in IDLE, to the arbitration winner. A request is accepted when `req && gnt`.
  - On acceptance, latch the requester, addr, we, size, and wdata, then go to BUSY.
  - Fetch requests always use size 10, we 0.
- Arbitration:
  - Data wins by default.
  - `burst_cnt` counts data grants issued while `if_req` is high.
  - When `burst_cnt == MAX_D_BURST`, fetch wins the next contested IDLE cycle.
  - `burst_cnt` clears on any fetch grant, or on any cycle with `if_req` low.
- Error check: an error is flagged if any of these hold:
  - size 11;
  - half with `addr[0]` set;
  - word with `addr[1:0]` nonzero;
  - `addr + bytes - 1 >= MEM_BYTES`.
- BUSY (always exactly one cycle, then IDLE):
  - Drive `mem_address` and `mem_size` from the latched request, and `mem_write_data` from wdata.
  - `mem_read = !we && !err`; `mem_write = we && !err && !rst`.
  - At the closing edge, capture `mem_read_data` into the response register (0 for writes or errors) and pulse the requester's `rvalid` for one cycle with `err`.
- Requester rules:
  - A requester holds req and its fields stable until granted.
  - Dropping req before grant is legal; no access occurs.
- The `rdata` register holds its value until the next response. `rdata` is sign-extended exactly as `Memory` returns it.

## Timing
- Request accepted at edge T. The memory access happens in cycle T+1. `rvalid` is high in cycle T+2.
- The write commits at the edge ending cycle T+1.
- IDLE coincides with the `rvalid` cycle, so a new grant can occur while the previous response is visible. Peak throughput is 1 access per 2 cycles.
- Both requesters are never granted in the same cycle.
- With `rst` high in any cycle:
  - the FSM goes to IDLE and `burst_cnt` clears;
  - no `rvalid` follows;
  - a BUSY write in that cycle is suppressed via `mem_write` gating.
- A write followed by a read of the same address returns the new data, because the read's BUSY cycle is at least 2 cycles after the write.

## Structure
- Package `mem_arb_pkg` holds:
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the FSM state encoding;
  - the requester-id constants `REQ_IF`, `REQ_D`.
- Sub-module `mem_arb_chk`: combinational alignment and range checker (inputs addr and size, output err), parameterized by `MEM_BYTES`.
- Top-level: FSM, arbitration counter, request/response registers, and memory drive mux.

## Test plan
- Fetch only: `if_addr=0x100` with `Memory` word `0xDEADBEEF` at 0x100 -> `if_gnt` at T, `mem_read=1` and `mem_address=0x100` at T+1, `if_rvalid=1` and `if_rdata=0xDEADBEEF` and `if_err=0` at T+2.
- Data byte write then load: store `d_size=00`, `d_addr=0x203`, `d_wdata=0x80` -> `d_rvalid` with err 0. Then byte load of 0x203 -> `d_rdata=0xFFFFFF80`.
- Errors:
  - word load at 0x202 -> `d_err=1`, `d_rdata=0`, `mem_read` never asserted;
  - word store at 8190 -> `d_err=1`, `mem_write` never asserted;
  - `d_size=11` -> `d_err=1`.
- Contention with `if_req` and `d_req` held high continuously -> grant sequence D,D,D,D,IF,D,D,D,D,IF.
- `rst` pulsed during the BUSY cycle of a word store to 0x40 -> `mem_write` stays 0, memory at 0x40 is unchanged, no `d_rvalid`, and the FSM is in IDLE the next cycle.
- Back-to-back data loads -> grants exactly every 2 cycles, each `rvalid` coinciding with the next `d_gnt`.
